// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the generic pipeline-stage register.
//               - Skid-stage state encoding (EMPTY / FULL / SKID).
//               - Field widths, bit offsets and packed layout of the ID/EX
//                 payload, plus the keep mask that preserves save_pc across
//                 a flush.
//               Payload packing order (MSB .. LSB):
//                 pc | rd_data1 | rd_data2 | extended_addr | reg_addr_wr |
//                 immediate | alu_opcode | prediction | save_pc
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // -------------------------------------------------------------------------
   // Stage state encoding
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   // -------------------------------------------------------------------------
   // ID/EX field widths
   // -------------------------------------------------------------------------
   localparam int ID_EX_PC_W            = 32;
   localparam int ID_EX_RD_DATA1_W      = 32;
   localparam int ID_EX_RD_DATA2_W      = 32;
   localparam int ID_EX_EXTENDED_ADDR_W = 32;
   localparam int ID_EX_REG_ADDR_WR_W   = 5;
   localparam int ID_EX_IMMEDIATE_W     = 32;
   localparam int ID_EX_ALU_OPCODE_W    = 4;
   localparam int ID_EX_PREDICTION_W    = 1;
   localparam int ID_EX_SAVE_PC_W       = 32;

   // -------------------------------------------------------------------------
   // ID/EX field bit offsets (LSB position of each field)
   // -------------------------------------------------------------------------
   localparam int ID_EX_SAVE_PC_LSB       = 0;
   localparam int ID_EX_PREDICTION_LSB    = ID_EX_SAVE_PC_LSB       + ID_EX_SAVE_PC_W;
   localparam int ID_EX_ALU_OPCODE_LSB    = ID_EX_PREDICTION_LSB    + ID_EX_PREDICTION_W;
   localparam int ID_EX_IMMEDIATE_LSB     = ID_EX_ALU_OPCODE_LSB    + ID_EX_ALU_OPCODE_W;
   localparam int ID_EX_REG_ADDR_WR_LSB   = ID_EX_IMMEDIATE_LSB     + ID_EX_IMMEDIATE_W;
   localparam int ID_EX_EXTENDED_ADDR_LSB = ID_EX_REG_ADDR_WR_LSB   + ID_EX_REG_ADDR_WR_W;
   localparam int ID_EX_RD_DATA2_LSB      = ID_EX_EXTENDED_ADDR_LSB + ID_EX_EXTENDED_ADDR_W;
   localparam int ID_EX_RD_DATA1_LSB      = ID_EX_RD_DATA2_LSB      + ID_EX_RD_DATA2_W;
   localparam int ID_EX_PC_LSB            = ID_EX_RD_DATA1_LSB      + ID_EX_RD_DATA1_W;

   // Total packed width of the ID/EX payload
   localparam int ID_EX_W = ID_EX_PC_LSB + ID_EX_PC_W;

   // -------------------------------------------------------------------------
   // Packed ID/EX payload; member order matches the offsets above
   // -------------------------------------------------------------------------
   typedef struct packed {
      logic [ID_EX_PC_W-1:0]            pc;
      logic [ID_EX_RD_DATA1_W-1:0]      rd_data1;
      logic [ID_EX_RD_DATA2_W-1:0]      rd_data2;
      logic [ID_EX_EXTENDED_ADDR_W-1:0] extended_addr;
      logic [ID_EX_REG_ADDR_WR_W-1:0]   reg_addr_wr;
      logic [ID_EX_IMMEDIATE_W-1:0]     immediate;
      logic [ID_EX_ALU_OPCODE_W-1:0]    alu_opcode;
      logic [ID_EX_PREDICTION_W-1:0]    prediction;
      logic [ID_EX_SAVE_PC_W-1:0]       save_pc;
   } id_ex_t;

   // -------------------------------------------------------------------------
   // Builds a mask with ones over [lsb +: width] of an ID/EX payload
   // -------------------------------------------------------------------------
   function automatic logic [ID_EX_W-1:0] id_ex_field_mask(input int lsb,
                                                           input int width);
      logic [ID_EX_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < ID_EX_W; i++) begin
         mask[i] = (i >= lsb) && (i < lsb + width);
      end
      return mask;
   endfunction

   // Only the saved PC survives a flush of the ID/EX stage
   localparam logic [ID_EX_W-1:0] ID_EX_KEEP_MASK =
      id_ex_field_mask(ID_EX_SAVE_PC_LSB, ID_EX_SAVE_PC_W);

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_cnt
// Description : Up-counter with enable that sticks at all-ones instead of
//               wrapping. Used for pipeline-stage statistics.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    : counter width in bits (>= 1)
// Ports
//   clk      : in  rising-edge clock
//   reset    : in  asynchronous active-low reset (clears the count)
//   i_en     : in  count this cycle
//   o_count  : out current count (registered)
// ============================================================================
module pipe_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_en && (r_count != c_MAX)) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign o_count = r_count;

endmodule : pipe_sat_cnt
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Generic pipeline-stage register with valid/ready handshake
//               and a 2-entry (main + skid) buffer. Back-pressure stalls
//               upstream one beat late without losing data, because the
//               skid register absorbs the beat accepted while in_ready was
//               still high. Flush empties the stage; payload bits set in
//               KEEP_MASK are loaded from in_data, all others are zeroed.
//               in_ready is registered, so out_ready never reaches in_ready
//               combinationally, and out_* are driven only from registers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option
//   PIPE_STAT_EN : when defined, adds saturating stall/flush counters and
//                  their output ports. Handshake and data are unaffected.
// Parameters
//   DATA_WIDTH   : payload width in bits (>= 1)
//   KEEP_MASK    : per-bit flush keep mask (1 = load from in_data on flush)
//   CNT_WIDTH    : statistics counter width (PIPE_STAT_EN only)
// Ports
//   clk          : in  rising-edge clock
//   reset        : in  asynchronous active-low reset
//   flush        : in  discard stage contents this cycle
//   in_valid     : in  upstream payload valid
//   in_ready     : out stage can accept (registered)
//   in_data      : in  upstream payload
//   out_valid    : out payload valid to downstream
//   out_ready    : in  downstream accepts
//   out_data     : out registered payload
//   stall_cnt    : out cycles with out_valid & !out_ready (PIPE_STAT_EN)
//   flush_cnt    : out cycles with flush asserted        (PIPE_STAT_EN)
// ============================================================================
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] KEEP_MASK  = {DATA_WIDTH{1'b0}},
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_STAT_EN
   ,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   pipe_state_e           r_state;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] r_skid;
   logic                  r_in_ready;

   logic                  w_accept;
   logic                  w_deliver;

   assign w_accept  = in_valid  & r_in_ready;
   assign w_deliver = out_valid & out_ready;

   // -------------------------------------------------------------------------
   // Stage control and datapath
   //   in_ready drops only when a beat lands in the skid register, i.e. when
   //   both entries are occupied; every other next-state can take one more.
   //   Out of reset in_ready starts low and rises on the first clock edge.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_in_ready <= 1'b0;
      end else if (flush) begin
         // Flush overrides the handshake: the beat on in_data is never
         // accepted, but its kept fields are captured for the next stage.
         r_state    <= EMPTY;
         r_main     <= in_data & KEEP_MASK;
         r_skid     <= '0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_main  <= in_data;
                  r_state <= FULL;
               end
            end

            FULL: begin
               if (w_accept && w_deliver) begin
                  r_main     <= in_data;
                  r_in_ready <= 1'b1;
               end else if (w_deliver) begin
                  // main keeps its last value; out_valid masks it
                  r_state    <= EMPTY;
                  r_in_ready <= 1'b1;
               end else if (w_accept) begin
                  r_skid     <= in_data;
                  r_state    <= SKID;
                  r_in_ready <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end

            SKID: begin
               if (w_deliver) begin
                  r_main     <= r_skid;
                  r_state    <= FULL;
                  r_in_ready <= 1'b1;
               end else begin
                  r_in_ready <= 1'b0;
               end
            end

            default: begin
               // Unreachable encoding: recover to an empty stage
               r_state    <= EMPTY;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign out_valid = (r_state != EMPTY);
   assign out_data  = r_main;
   assign in_ready  = r_in_ready;

   // -------------------------------------------------------------------------
   // Optional statistics
   // -------------------------------------------------------------------------
`ifdef PIPE_STAT_EN
   logic w_stall;

   assign w_stall = out_valid & ~out_ready;

   pipe_sat_cnt #(
      .WIDTH   (CNT_WIDTH)
   ) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_stall),
      .o_count (stall_cnt)
   );

   pipe_sat_cnt #(
      .WIDTH   (CNT_WIDTH)
   ) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_en    (flush),
      .o_count (flush_cnt)
   );
`else
   // Counter width has no effect without statistics
   logic w_unused_cnt_cfg;
   assign w_unused_cnt_cfg = (CNT_WIDTH > 0);
`endif

endmodule : pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register that replaces hand-written per-stage registers such as IF/ID, ID/EX and EX/MEM.
- Carries one packed payload bus with a valid/ready handshake.
- A 2-entry skid buffer lets back-pressure stall upstream without dropping data.
- Supports flush with a per-bit keep mask, so selected fields (e.g. saved PC) survive a flush while all other fields are zeroed.

Parameters:
- DATA_WIDTH, 32: packed payload width in bits; must be ≥1.
- KEEP_MASK, {DATA_WIDTH{1'b0}}: bit=1 means that payload bit loads from in_data on flush; bit=0 means it is zeroed.
- CNT_WIDTH, 16: width of the statistics counters (used only with PIPE_STAT_EN).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- flush, input, 1: kill stage contents this cycle.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: stage can accept; registered.
- in_data, input, DATA_WIDTH: upstream payload.
- out_valid, output, 1: payload valid to downstream.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_WIDTH: registered payload.
- stall_cnt, output, CNT_WIDTH: present only with PIPE_STAT_EN.
- flush_cnt, output, CNT_WIDTH: present only with PIPE_STAT_EN.

Behaviour:
- Storage:
  - main register drives out_data.
  - skid register holds one extra beat.
  - 2-bit state: EMPTY, FULL, SKID.
- Transfers:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - out_valid = (state != EMPTY).
- Latency:
  - 1 cycle from accept to out_valid.
  - No combinational path from in_* to out_*.
  - No combinational path from out_ready to in_ready.
- Reset (reset=0, async):
  - state=EMPTY; main=0; skid=0; out_valid=0; in_ready=0; counters=0.
  - First rising edge after reset deassertion sets in_ready=1.
- State transitions (no flush):
  - EMPTY, accept: main<=in_data; go to FULL.
  - EMPTY, no accept: stay.
  - FULL, accept & deliver: main<=in_data; stay FULL.
  - FULL, deliver only: go to EMPTY; main holds its last value.
  - FULL, accept only: skid<=in_data; go to SKID; in_ready<=0.
  - FULL, neither: hold.
  - SKID, deliver: main<=skid; go to FULL; in_ready<=1.
  - SKID, no deliver: hold; in_ready stays 0.
- Flush:
  - Priority is below reset and above all handshake activity.
  - Effects:
    - state<=EMPTY.
    - main<=in_data & KEEP_MASK, regardless of in_valid.
    - skid<=0.
    - in_ready<=1.
  - The beat on in_data is never counted as accepted.
  - A deliver in the same cycle as flush is still consumed downstream (out_valid was 1 before the edge); this is permitted.
- Flush while in SKID: both beats are discarded.
- Reset mid-transfer: all beats are discarded; nothing is replayed.
- Payload bits are not interpreted by this block; packing order is defined by the package.

Optional Feature:
- Macro: PIPE_STAT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both counters saturate at all-ones and reset to 0.
- Not defined:
  - The counter ports and logic are absent.
  - Handshake/data behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - field widths and bit offsets for the ID/EX payload (pc, rd_data1, rd_data2, extended_addr, reg_addr_wr, immediate, alu_opcode, prediction, save_pc);
  - total width ID_EX_W;
  - constant ID_EX_KEEP_MASK (save_pc field bits = 1, all others 0);
  - state enum values EMPTY=0, FULL=1, SKID=2.
- One sub-module, pipe_sat_cnt: saturating counter with an enable input, instantiated twice under PIPE_STAT_EN.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  - During reset: out_valid=0, out_data=0, in_ready=0.
  - One cycle after release: in_ready=1.
- Streaming: out_ready=1; push 0x11, 0x22, 0x33 on consecutive cycles.
  - out_data shows 0x11, 0x22, 0x33 one cycle later.
  - out_valid=1 for exactly 3 cycles.
- Back-pressure: with FULL holding 0xA0 and out_ready=0, push 0xB0.
  - Next cycle: state=SKID, in_ready=0, out_data=0xA0.
  - Raise out_ready: 0xA0 delivers, then 0xB0 delivers; in_ready returns to 1.
- Flush with keep mask: KEEP_MASK=0x0000FFFF, DATA_WIDTH=32, in SKID state; pulse flush with in_data=0xDEADBEEF.
  - Next cycle: out_valid=0, main=0x0000BEEF, in_ready=1, skid=0.
- Simultaneous: in FULL, drive in_valid=1, out_ready=1 and flush=1 together.
  - Result: EMPTY; accepted count unchanged; old beat delivered once.
- PIPE_STAT_EN with CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles.
  - stall_cnt saturates at 15.
  - 2 flush pulses give flush_cnt=2.
